aes_result_spi_tx: RTL

AES_RESULT_SPI_TX -- requirements
Module: aes_result_spi_tx

---
 rtl/aes_result_spi_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/aes_result_spi_tx.sv
// Holds one decrypted AES result and shifts it out MSB first to an
// external SPI mode-0 master, with sclk/cs_n synchronized into clk.
module aes_result_spi_tx #(
   parameter int DATA_W      = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flag,
   input  logic [DATA_W-1:0] data_in,
   input  logic              sclk,
   input  logic              cs_n,
   output logic              miso,
   output logic              loaded,
   output logic              tx_done,
   output logic              overflow
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   sclk_ed_q, sclk_ed_d;
   logic                   cs_ed_q, cs_ed_d;
   logic                   flag_ed_q, flag_ed_d;
   logic [DATA_W-1:0]      shift_q, shift_d;
   logic [DATA_W-1:0]      hold_q, hold_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   tx_done_q, tx_done_d;
   logic                   ovf_q, ovf_d;

   logic sclk_s, cs_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic flag_rise, last_bit;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_ed_q;
   assign sclk_fall = ~sclk_s & sclk_ed_q;
   assign cs_rise   = cs_s & ~cs_ed_q;
   assign cs_fall   = ~cs_s & cs_ed_q;
   assign flag_rise = flag & ~flag_ed_q;
   assign last_bit  = (cnt_q == CNT_W'(DATA_W - 1));

   always_comb begin
      sclk_sync_d    = sclk_sync_q;
      cs_sync_d      = cs_sync_q;
      sclk_sync_d[0] = sclk;
      cs_sync_d[0]   = cs_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sclk_sync_d[i] = sclk_sync_q[i-1];
         cs_sync_d[i]   = cs_sync_q[i-1];
      end
      sclk_ed_d = sclk_s;
      cs_ed_d   = cs_s;
      flag_ed_d = flag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         sclk_ed_q   <= 1'b0;
         cs_ed_q     <= 1'b0;
         flag_ed_q   <= 1'b0;
         shift_q     <= '0;
         hold_q      <= '0;
         cnt_q       <= '0;
         tx_done_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         sclk_ed_q   <= sclk_ed_d;
         cs_ed_q     <= cs_ed_d;
         flag_ed_q   <= flag_ed_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         cnt_q       <= cnt_d;
         tx_done_q   <= tx_done_d;
         ovf_q       <= ovf_d;
      end
   end

   // Chip-select level, not its edges, governs entry and abort.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (flag_rise) state_d = LOADED;
         LOADED:  if (!cs_s) state_d = SHIFT;
         SHIFT: begin
            if (cs_s)                       state_d = LOADED;
            else if (sclk_rise && last_bit) state_d = DONE;
         end
         DONE:    if (cs_s) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shift_d   = shift_q;
      hold_d    = hold_q;
      cnt_d     = cnt_q;
      tx_done_d = (state_q == SHIFT) && (state_d == DONE);
      ovf_d     = flag_rise && (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (flag_rise) begin
               shift_d = data_in;
               hold_d  = data_in;
            end
         end
         LOADED: begin
            if (!cs_s) begin
               shift_d = hold_q;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (!cs_s) begin
               if (sclk_rise) cnt_d = cnt_q + CNT_W'(1);
               if (sclk_fall) shift_d = {shift_q[DATA_W-2:0], 1'b0};
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      miso     = (state_q == SHIFT) ? shift_q[DATA_W-1] : 1'b0;
      loaded   = (state_q == LOADED) || (state_q == SHIFT);
      tx_done  = tx_done_q;
      overflow = ovf_q;
   end

   logic unused_edges;
   assign unused_edges = cs_rise ^ cs_fall;

endmodule
